sliced_add_sequencer: RTL and testbench

- Multi-cycle add/subtract controller. It performs one WIDTH-bit operation by stepping a single SLICE-bit adder slice across the operands, one slice per clock, least significant slice first.
- A registered carry links consecutive slices.
- It sits between the register-file read stage and write-back, where a full-width adder costs too much area. Operands and results move over valid/ready handshakes.
- Flags (carry, signed overflow, zero) feed the condition-code register.

---
 rtl/sliced_add_sequencer_if.sv | 31 +++
 rtl/sliced_add_sequencer.sv | 131 +++++++++++++
 tb/tb_sliced_add_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sliced_add_sequencer_if.sv
// Handshake and data bundle for the sliced add/subtract sequencer.
// The producer/consumer side uses 'master'; the sequencer itself uses 'slave'.
interface sliced_add_sequencer_if #(
  parameter int WIDTH = 32
);
  // Operand request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] augend;
  logic [WIDTH-1:0] addend;
  logic             cin;
  logic             sub;

  // Result channel with condition-code flags
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, augend, addend, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero
  );

  modport slave (
    input  in_valid, augend, addend, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero
  );
endinterface

// File: rtl/sliced_add_sequencer.sv
// Multi-cycle add/subtract unit: one SLICE-bit adder is stepped across the
// operands, least significant slice first, with a registered carry linking
// consecutive slices. WIDTH must be an integer multiple of SLICE, and the
// interface instance must carry the same WIDTH as this module.
module sliced_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                   clock,
  input logic                   reset,
  sliced_add_sequencer_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aug_q, aug_d;
  logic [WIDTH-1:0] add_q, add_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  int               slice_base;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_r;

  // Slice adder: pick the active slice of each operand and add the link carry.
  always_comb begin
    slice_base = int'(cnt_q) * SLICE;
    slice_a    = aug_q[slice_base +: SLICE];
    slice_b    = add_q[slice_base +: SLICE];
    slice_r    = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, cy_q};
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    aug_d   = aug_q;
    add_d   = add_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is addition of the inverted addend; the carry-in
          // flips so that a borrow-in of 1 subtracts one more.
          aug_d   = bus.augend;
          add_d   = bus.sub ? ~bus.addend : bus.addend;
          cy_d    = bus.cin ^ bus.sub;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d[slice_base +: SLICE] = slice_r[SLICE-1:0];
        cy_d  = slice_r[SLICE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          carry_d = slice_r[SLICE];
          ovf_d   = (aug_q[WIDTH-1] == add_q[WIDTH-1]) &&
                    (slice_r[SLICE-1] != aug_q[WIDTH-1]);
          zero_d  = (sum_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state, result and flags, all cleared by synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Operand holding registers.
  always_ff @(posedge clock) begin
    // NOTE: no reset here; they are always loaded on accept before any use.
    aug_q <= aug_d;
    add_q <= add_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sliced_add_sequencer.sv
// Scoreboard bench for sliced_add_sequencer (WIDTH=32, SLICE=8).
// Stimulus pushes hand-computed results; a monitor compares on out_valid.
module tb_sliced_add_sequencer;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        overflow;
    logic        zero;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_q[$];
  int   acc_q[$];
  int   rise_q[$];

  sliced_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  sliced_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb,
                       input logic [31:0] es, input logic ec,
                       input logic ev, input logic ez);
    bit ok;
    ok = 1'b0;
    exp_q.push_back('{es, ec, ev, ez});
    bus.augend   = a;
    bus.addend   = b;
    bus.cin      = ci;
    bus.sub      = sb;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    check("accept within budget", 32'(ok), 32'd1);
  endtask

  // Wait for every pending result to be consumed; returns at a negedge.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    check("drain within budget", 32'(ok), 32'd1);
    @(negedge clock);
  endtask

  // Monitor: latency, flag/result comparison and in-order consumption.
  initial begin : monitor
    logic prev_ov;
    int   a;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        acc_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
        if (bus.out_valid) begin
          if (!prev_ov) begin
            rise_q.push_back(cyc);
            if (acc_q.size() == 0) begin
              check("result without accept", 32'(acc_q.size()), 32'd1);
            end else begin
              a = acc_q.pop_front();
              check("latency", 32'(cyc - a), 32'(N));
            end
          end
          check("in_ready low in DONE", 32'(bus.in_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected result", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q[0];
            check("sum",      bus.sum,            e.sum);
            check("carry",    32'(bus.carry),     32'(e.carry));
            check("overflow", 32'(bus.overflow),  32'(e.overflow));
            check("zero",     32'(bus.zero),      32'(e.zero));
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    bus.in_valid  = 1'b0;
    bus.augend    = '0;
    bus.addend    = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset sum",       bus.sum,            32'd0);
    check("reset carry",     32'(bus.carry),     32'd0);
    check("reset overflow",  32'(bus.overflow),  32'd0);
    check("reset zero",      32'(bus.zero),      32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Additions: inter-slice carry, full wrap, signed overflow
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drain();

    // Subtractions: borrow, signed overflow, borrow-in
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    drain();
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    drain();
    issue(32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
    drain();

    // Backpressure in DONE with a competing request on the input side
    bus.out_ready = 1'b0;
    issue(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 32'h0000_2345, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      #1;
      if (bus.out_valid) ok = 1'b1;
    end
    check("reach DONE within budget", 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k == 0) begin
        exp_q.push_back('{32'h0000_0300, 1'b0, 1'b0, 1'b0});
        bus.augend   = 32'h0000_0100;
        bus.addend   = 32'h0000_0200;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
      end
      #1;
      check("bp in_ready",  32'(bus.in_ready),  32'd0);
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(negedge clock);
    #1;
    check("bp idle in_ready",  32'(bus.in_ready),  32'd1);
    check("bp idle out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    check("bp accepted in_ready", 32'(bus.in_ready), 32'd0);
    check("bp accepted out_valid", 32'(bus.out_valid), 32'd0);
    drain();

    // Reset on the edge after slice 1 completes
    issue(32'h0000_0055, 32'h0000_0066, 1'b0, 1'b0, 32'h0000_00BB, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid reset in_ready",  32'(bus.in_ready),  32'd1);
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset sum",       bus.sum,            32'd0);
    check("mid reset carry",     32'(bus.carry),     32'd0);
    @(negedge clock);
    issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back with in_valid and out_ready held high
    rise_q.delete();
    issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();
    check("b2b result count", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      check("b2b spacing 1", 32'(rise_q[1] - rise_q[0]), 32'(N + 2));
      check("b2b spacing 2", 32'(rise_q[2] - rise_q[1]), 32'(N + 2));
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
